alu_req_arbiter: RTL and testbench

- Round-robin scheduler that shares one 4-bit combinational ALU between NREQ requesters.
- Each requester presents an operand/opcode bundle under a valid/ready handshake.
- The arbiter grants one requester, drives the shared ALU from registered operands, and captures the result. It returns the result on a single response channel tagged with the requester id.
- Sits between the requesting control units and the ALU datapath.

---
 rtl/alu_arb_pkg.sv | 28 ++
 rtl/alu_req_arbiter_rr_pick.sv | 30 +++
 rtl/alu_req_arbiter.sv | 101 ++++++++++
 tb/tb_alu_req_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the round-robin ALU request arbiter: FSM states,
// ALU opcode map and the supported-opcode check.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [3:0] OP_NAND = 4'b0000;
    localparam logic [3:0] OP_NOR  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_ADDC = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            OP_NAND, OP_NOR, OP_XOR, OP_INV,
            OP_SHL, OP_ADD, OP_ADDC, OP_SUB: op_supported = 1'b1;
            default:                         op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr
// upward, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any_valid
);

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any_valid && req[j]) begin
                any_valid = 1'b1;
                grant[j]  = 1'b1;
                idx       = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin scheduler sharing one external combinational ALU between NREQ
// requesters; one op in flight, result returned on a tagged response channel.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    input  logic [NREQ-1:0]   req_cin,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_cin,
    input  logic [W-1:0]      alu_res,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_cout,
    output logic              rsp_err
);

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Ready is offered only while idle, so a request arriving during the
    // response handshake waits for the following IDLE cycle.
    assign req_ready = (rst_n && state == IDLE) ? pick_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        alu_a    <= req_a[pick_idx*W +: W];
                        alu_b    <= req_b[pick_idx*W +: W];
                        alu_op   <= req_op[pick_idx*4 +: 4];
                        alu_cin  <= req_cin[pick_idx];
                        grant_id <= pick_idx;
                        state    <= EXEC;
                    end
                end
                // ALU has settled from the registered operands; capture it.
                EXEC: begin
                    rsp_data  <= alu_res;
                    rsp_cout  <= alu_cout;
                    rsp_id    <= grant_id;
                    rsp_err   <= !op_supported(alu_op);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: table of single-request vectors plus
// sequences for rotation, backpressure and reset during execution.
module tb_alu_req_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_op;
    logic              alu_cin;
    logic [W-1:0]      alu_res;
    logic              alu_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_cout;
    logic              rsp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_cin   (req_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_cin   (alu_cin),
        .alu_res   (alu_res),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err)
    );

    // External 4-bit ALU; SUB reports borrow on cout, unsupported ops give 0.
    always_comb begin
        logic [4:0] t;
        t = 5'd0;
        case (alu_op)
            4'b0000: t = {1'b0, ~(alu_a & alu_b)};
            4'b0001: t = {1'b0, ~(alu_a | alu_b)};
            4'b0010: t = {1'b0, alu_a ^ alu_b};
            4'b0100: t = {1'b0, ~alu_a};
            4'b0101: t = {alu_a, alu_cin};
            4'b1000: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'b1001: t = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
            4'b1010: t = {1'b0, alu_a} - {1'b0, alu_b};
            default: t = 5'd0;
        endcase
        alu_res  = t[3:0];
        alu_cout = t[4];
    end

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       cin;
        logic [3:0] d;
        logic       c;
        logic       e;
    } vec_t;

    vec_t vt[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic cin);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*4 +: 4] = op;
        req_cin[id]       = cin;
    endtask

    initial begin
        int order[5];
        logic [3:0] rr_exp[4];
        int nacc, nrsp, last;
        logic clr;

        vt[0] = '{2, 4'h5, 4'h3, 4'b1000, 1'b0, 4'h8, 1'b0, 1'b0};
        vt[1] = '{0, 4'hC, 4'hA, 4'b0000, 1'b0, 4'h7, 1'b0, 1'b0};
        vt[2] = '{3, 4'h5, 4'h2, 4'b0001, 1'b0, 4'h8, 1'b0, 1'b0};
        vt[3] = '{1, 4'h6, 4'h3, 4'b0010, 1'b0, 4'h5, 1'b0, 1'b0};
        vt[4] = '{2, 4'h3, 4'h0, 4'b0100, 1'b0, 4'hC, 1'b0, 1'b0};
        vt[5] = '{0, 4'h9, 4'h0, 4'b0101, 1'b1, 4'h3, 1'b1, 1'b0};
        vt[6] = '{3, 4'hF, 4'h0, 4'b1001, 1'b1, 4'h0, 1'b1, 1'b0};
        vt[7] = '{1, 4'h7, 4'h1, 4'b0011, 1'b0, 4'h0, 1'b0, 1'b1};
        order  = '{0, 1, 2, 3, 0};
        rr_exp = '{4'h2, 4'hA, 4'hF, 4'h9};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        req_cin = '0; rsp_ready = 1'b0;

        // Reset then idle
        step(); step();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_op, alu_cin}), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err}), 0);
        rst_n = 1'b1;
        step(); step(); step();
        chk("idle_ready", 32'(req_ready), 0);
        chk("idle_valid", 32'(rsp_valid), 0);

        // Table of single requests, rsp_ready held high
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].op, vt[i].cin);
            req_valid = NREQ'(1 << vt[i].id);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(1) << vt[i].id);
            step();
            req_valid = '0;
            chk($sformatf("v%0d_alu", i), 32'({alu_a, alu_b, alu_op}), 32'({vt[i].a, vt[i].b, vt[i].op}));
            chk($sformatf("v%0d_exec_ready", i), 32'(req_ready), 0);
            step();
            chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(vt[i].id));
            chk($sformatf("v%0d_data", i), 32'(rsp_data), 32'(vt[i].d));
            chk($sformatf("v%0d_cout", i), 32'(rsp_cout), 32'(vt[i].c));
            chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(vt[i].e));
            step();
            chk($sformatf("v%0d_done", i), 32'(rsp_valid), 0);
        end

        // Reset during EXEC: ptr is now 2, so requester 3 wins first
        set_req(1, 4'h2, 4'h2, 4'b1000, 1'b0);
        set_req(3, 4'h4, 4'h4, 4'b1000, 1'b0);
        req_valid = 4'b1010;
        #1;
        chk("mr_ready3", 32'(req_ready), 32'h8);
        step();
        chk("mr_exec_a", 32'(alu_a), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mr_ready_in_rst", 32'(req_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mr_no_rsp", 32'(rsp_valid), 0);
        chk("mr_alu_clr", 32'({alu_a, alu_b, alu_op, alu_cin}), 0);
        chk("mr_ready_low", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1000;
        step();
        chk("mr_rsp1_id", 32'(rsp_id), 1);
        chk("mr_rsp1_data", 32'(rsp_data), 32'h4);
        step();
        chk("mr_ready3b", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        step();
        chk("mr_rsp3_id", 32'(rsp_id), 3);
        chk("mr_rsp3_data", 32'(rsp_data), 32'h8);
        step();

        // Round-robin rotation, all four requesting continuously
        set_req(0, 4'h1, 4'h1, 4'b1000, 1'b0);
        set_req(1, 4'h5, 4'hF, 4'b0010, 1'b0);
        set_req(2, 4'h0, 4'h0, 4'b0001, 1'b0);
        set_req(3, 4'h6, 4'h0, 4'b0100, 1'b0);
        req_valid = 4'hF;
        #1;
        nacc = 0; nrsp = 0; last = 0; clr = 1'b0;
        for (int cyc = 0; cyc < 40 && nrsp < 5; cyc++) begin
            if (req_ready != '0 && nacc < 5) begin
                chk($sformatf("rr_grant%0d", nacc), 32'(req_ready), 32'(1) << order[nacc]);
                if (nacc > 0) chk($sformatf("rr_space%0d", nacc), 32'(cyc - last), 3);
                last = cyc;
                nacc++;
                if (nacc == 5) clr = 1'b1;
            end
            if (rsp_valid) begin
                chk($sformatf("rr_id%0d", nrsp), 32'(rsp_id), 32'(order[nrsp]));
                chk($sformatf("rr_data%0d", nrsp), 32'(rsp_data), 32'(rr_exp[order[nrsp]]));
                nrsp++;
            end
            step();
            if (clr) begin
                req_valid = '0;
                clr = 1'b0;
                #1;
            end
        end
        chk("rr_rsp_count", 32'(nrsp), 5);
        step();
        chk("rr_done", 32'(rsp_valid), 0);

        // Backpressure: ptr is now 1; requester 3 waits behind requester 1
        rsp_ready = 1'b0;
        set_req(1, 4'h1, 4'h2, 4'b1010, 1'b0);
        set_req(3, 4'h7, 4'h9, 4'b1000, 1'b0);
        req_valid = 4'b1010;
        #1;
        chk("bp_ready1", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1000;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d", k),
                32'({rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err}),
                32'({1'b1, 2'd1, 4'hF, 1'b1, 1'b0}));
            chk($sformatf("bp_ready%0d", k), 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        chk("bp_still_valid", 32'(rsp_valid), 1);
        step();
        chk("bp_ready3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        step();
        chk("bp_rsp3", 32'({rsp_valid, rsp_id, rsp_data, rsp_cout}), 32'({1'b1, 2'd3, 4'h0, 1'b1}));
        step();
        chk("bp_done", 32'(rsp_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
